gtp_tx_sched: RTL and testbench
===============================

Name: gtp_tx_sched

Overview:
- Schedules GTP transmit channel 0 of the channel FPGA at CLK125.
- Multiplexes three sources onto one 16-bit word plus one K flag: data blocks from a show-ahead block FIFO, trigger K-characters, and comma/filler idle words.
- Trigger characters take priority and may interrupt a data block mid-stream; the block resumes afterwards with no loss of data.
- Output feeds gtp_data_i[15:0] and gtp_comma_i[0] of the GTP wrapper.

Parameters:
- MIN_GAP, 2: minimum number of COMMA words sent after a block's last word before the next block may start (1..15).
- COMMA, 16'h50BC: idle word, sent with K=1.
- TRIG_K, 16'h00FC: trigger character, sent with K=1.
- FILL_K, 16'h003C: in-block underflow filler, sent with K=1.

Ports:
- CLK  in  1  125 MHz clock.
- RST_N  in  1  asynchronous reset, active-low.
- ENABLE  in  1  allows new blocks to start.
- TRIG  in  1  trigger request, one pulse per trigger.
- TRIG_TS  in  16  trigger timestamp; used only with TRIG_TIMESTAMP_EN.
- BLK_EMPTY  in  1  block FIFO empty.
- BLK_DAT  in  16  FIFO head word (show-ahead).
- BLK_LAST  in  1  head word is the last word of its block.
- BLK_RD  out  1  pop FIFO head; combinational.
- GTP_DATA  out  16  word to GTP; registered.
- GTP_K  out  1  charisk for GTP_DATA; registered.
- BUSY  out  1  high in BLOCK state.
- CNT_BLK  out  16  blocks completed; wraps.
- CNT_TRIG  out  16  trigger characters sent; wraps.
- CNT_LOST  out  8  triggers dropped; saturates at 255.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, gap counter=MIN_GAP.
  - GTP_DATA=COMMA, GTP_K=1, BLK_RD=0, BUSY=0.
  - All counters 0, trig_pend=0.
- Reset asserted mid-block: the partial block is abandoned. The next block starts from whatever word is at the FIFO head; flushing the FIFO is the FIFO owner's job.
- trig_pend:
  - Set on any rising edge with TRIG=1.
  - Cleared on the edge that loads TRIG_K into GTP_DATA.
- Trigger priority: if trig_pend=1 at an edge, GTP_DATA<=TRIG_K, GTP_K<=1, BLK_RD=0 in that cycle, and CNT_TRIG increments. This holds in every state.
- Trigger latency: TRIG sampled high at edge k gives TRIG_K on the outputs from edge k+1. Back-to-back TRIG pulses produce back-to-back TRIG_K words.
- Simultaneous TRIG=1 and trig_pend=1 at one edge: the pending trigger is sent and pend stays set, so the new trigger is not lost.
- State IDLE:
  - Output COMMA. Gap counter decrements each cycle down to 0.
  - If ENABLE=1, gap counter=0, BLK_EMPTY=0 and trig_pend=0: BLK_RD=1, GTP_DATA<=BLK_DAT with K=0.
  - Then go to BLOCK, or stay in IDLE with gap reload if BLK_LAST=1 (single-word block).
- State BLOCK:
  - If BLK_EMPTY=0 and trig_pend=0: BLK_RD=1 and BLK_DAT is sent with K=0.
  - If BLK_EMPTY=1 and trig_pend=0: send FILL_K with K=1; BLK_RD=0.
  - When a word with BLK_LAST=1 is popped: CNT_BLK++, gap counter<=MIN_GAP, go to IDLE.
  - ENABLE going low in BLOCK does not stop the block; it only prevents the next start.
- BLK_RD is never asserted when BLK_EMPTY=1.
- Data words always carry K=0. Each FIFO word is sent exactly once, in order.
- Trigger words do not count against the gap. A trigger in IDLE sends TRIG_K while the gap counter still decrements.

Optional Feature:
- Macro: TRIG_TIMESTAMP_EN.
- Defined:
  - TRIG_TS is captured at the edge TRIG is sampled.
  - TRIG_K is followed in the next cycle by the captured TRIG_TS with K=0, using extra state TRIG_TS.
  - A TRIG arriving while a timestamp is already pending and unsent is dropped, and CNT_LOST increments (saturating).
  - Blocks pause for 2 cycles per trigger.
- Undefined: the TRIG_TS port is unused, each trigger is one word, and CNT_LOST stays 0.

Test Plan:
- Reset, no stimulus, ENABLE=1, FIFO empty → GTP_DATA=16'h50BC, GTP_K=1 every cycle; all counters 0.
- FIFO holds 4 words 16'h0001..16'h0004, LAST on the 4th → words appear on 4 consecutive cycles with K=0, then ≥2 COMMAs; CNT_BLK=1; BUSY high for 3 cycles.
- Two 3-word blocks queued, MIN_GAP=2 → exactly 2 COMMAs between the last word of block 1 and the first word of block 2.
- TRIG pulse during word 2 of a 4-word block → output sequence 0001, 00FC(K=1), 0002, 0003, 0004; no word lost; CNT_TRIG=1.
- FIFO runs empty after word 2 of a 4-word block for 3 cycles → three 16'h003C K=1 words, then 0003, 0004; CNT_BLK=1.
- With TRIG_TIMESTAMP_EN: TRIG at consecutive edges with TRIG_TS=16'h1234, then 16'h5678 → 00FC, 1234, 00FC, 5678. Three TRIGs on consecutive edges → third dropped, CNT_LOST=1.

Source files
------------

// File: rtl/gtp_tx_sched.sv
// gtp_tx_sched: GTP TX channel-0 scheduler for block data, trigger K-chars and idle commas.
// Optional `TRIG_TIMESTAMP_EN: each trigger K-char is followed by its 16-bit timestamp.
module gtp_tx_sched #(
    parameter int          MIN_GAP = 2,
    parameter logic [15:0] COMMA   = 16'h50BC,
    parameter logic [15:0] TRIG_K  = 16'h00FC,
    parameter logic [15:0] FILL_K  = 16'h003C
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        TRIG,
    input  logic [15:0] TRIG_TS,
    input  logic        BLK_EMPTY,
    input  logic [15:0] BLK_DAT,
    input  logic        BLK_LAST,
    output logic        BLK_RD,
    output logic [15:0] GTP_DATA,
    output logic        GTP_K,
    output logic        BUSY,
    output logic [15:0] CNT_BLK,
    output logic [15:0] CNT_TRIG,
    output logic [7:0]  CNT_LOST
);
    typedef enum logic [1:0] {S_IDLE, S_BLOCK, S_TRIG_TS} state_t;

    localparam logic [3:0] GAP_INIT = 4'(MIN_GAP);

    state_t      state_q, state_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] data_q, data_d;
    logic        k_q, k_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_blk_q, cnt_blk_d;
    logic [15:0] cnt_trig_q, cnt_trig_d;
    logic [7:0]  cnt_lost_q, cnt_lost_d;
    logic        send_trig;
    logic        pop;
    logic        gap_zero;
    logic [3:0]  gap_dec;

`ifdef TRIG_TIMESTAMP_EN
    logic [15:0] pts_q, pts_d;
    logic [15:0] ots_q, ots_d;
    logic        ret_q, ret_d;
`else
    logic unused_ts;
    assign unused_ts = ^TRIG_TS;
`endif

    always_comb begin
        gap_zero   = (gap_q == 4'd0);
        gap_dec    = gap_zero ? 4'd0 : gap_q - 4'd1;
`ifdef TRIG_TIMESTAMP_EN
        // The timestamp word must directly follow its K-char, so it wins
        send_trig  = pend_q && (state_q != S_TRIG_TS);
`else
        send_trig  = pend_q;
`endif
        state_d    = state_q;
        gap_d      = gap_q;
        data_d     = COMMA;
        k_d        = 1'b1;
        pop        = 1'b0;
        cnt_blk_d  = cnt_blk_q;
        cnt_trig_d = cnt_trig_q;
        cnt_lost_d = cnt_lost_q;
        pend_d     = TRIG | (pend_q & ~send_trig);
`ifdef TRIG_TIMESTAMP_EN
        pts_d      = pts_q;
        ots_d      = ots_q;
        ret_d      = ret_q;
        if (TRIG) begin
            if (pend_q && !send_trig) begin
                if (cnt_lost_q != 8'hFF) begin
                    cnt_lost_d = cnt_lost_q + 8'd1;
                end
            end else begin
                pts_d = TRIG_TS;
            end
        end
`endif
        if (send_trig) begin
            data_d     = TRIG_K;
            cnt_trig_d = cnt_trig_q + 16'd1;
`ifdef TRIG_TIMESTAMP_EN
            ots_d      = pts_q;
            ret_d      = (state_q == S_BLOCK);
            state_d    = S_TRIG_TS;
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                gap_d = gap_dec;
                if (!send_trig && ENABLE && gap_zero && !BLK_EMPTY) begin
                    pop = 1'b1;
                    if (BLK_LAST) begin
                        gap_d = GAP_INIT;
                    end else begin
                        state_d = S_BLOCK;
                    end
                end
            end
            S_BLOCK: begin
                if (!send_trig) begin
                    if (!BLK_EMPTY) begin
                        pop = 1'b1;
                    end else begin
                        data_d = FILL_K;
                    end
                end
                if (pop && BLK_LAST) begin
                    gap_d   = GAP_INIT;
                    state_d = S_IDLE;
                end
            end
`ifdef TRIG_TIMESTAMP_EN
            S_TRIG_TS: begin
                data_d = ots_q;
                k_d    = 1'b0;
                if (ret_q) begin
                    state_d = S_BLOCK;
                end else begin
                    state_d = S_IDLE;
                    gap_d   = gap_dec;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            data_d = BLK_DAT;
            k_d    = 1'b0;
            if (BLK_LAST) begin
                cnt_blk_d = cnt_blk_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            gap_q      <= GAP_INIT;
            data_q     <= COMMA;
            k_q        <= 1'b1;
            pend_q     <= 1'b0;
            cnt_blk_q  <= 16'd0;
            cnt_trig_q <= 16'd0;
            cnt_lost_q <= 8'd0;
`ifdef TRIG_TIMESTAMP_EN
            pts_q      <= 16'd0;
            ots_q      <= 16'd0;
            ret_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            k_q        <= k_d;
            pend_q     <= pend_d;
            cnt_blk_q  <= cnt_blk_d;
            cnt_trig_q <= cnt_trig_d;
            cnt_lost_q <= cnt_lost_d;
`ifdef TRIG_TIMESTAMP_EN
            pts_q      <= pts_d;
            ots_q      <= ots_d;
            ret_q      <= ret_d;
`endif
        end
    end

    assign BLK_RD   = pop;
    assign GTP_DATA = data_q;
    assign GTP_K    = k_q;
`ifdef TRIG_TIMESTAMP_EN
    assign BUSY     = (state_q == S_BLOCK) || ((state_q == S_TRIG_TS) && ret_q);
`else
    assign BUSY     = (state_q == S_BLOCK);
`endif
    assign CNT_BLK  = cnt_blk_q;
    assign CNT_TRIG = cnt_trig_q;
    assign CNT_LOST = cnt_lost_q;

endmodule

// File: tb/tb_gtp_tx_sched.sv
// tb_gtp_tx_sched: directed vector table plus randomized run against a cycle reference model.
module tb_gtp_tx_sched;
    localparam logic [15:0] COMMA   = 16'h50BC;
    localparam logic [15:0] TRIG_K  = 16'h00FC;
    localparam logic [15:0] FILL_K  = 16'h003C;
    localparam int          MIN_GAP = 2;

    typedef struct {
        logic [15:0] d;
        logic        last;
    } word_t;

    typedef struct {
        int          seg;
        logic        en;
        logic        trig;
        logic [15:0] ts;
        logic        stall;
        logic [15:0] exp_d;
        logic        exp_k;
        logic        exp_busy;
    } vec_t;

    localparam int EXP_BLK  [8] = '{0, 1, 2, 1, 1, 2, 1, 0};
    localparam int EXP_TRIG [8] = '{0, 0, 0, 1, 0, 1, 2, 2};
    localparam int EXP_LOST [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        TRIG = 1'b0;
    logic [15:0] TRIG_TS = 16'h0;
    logic        BLK_EMPTY = 1'b1;
    logic [15:0] BLK_DAT = 16'h0;
    logic        BLK_LAST = 1'b0;
    logic        BLK_RD;
    logic [15:0] GTP_DATA;
    logic        GTP_K;
    logic        BUSY;
    logic [15:0] CNT_BLK;
    logic [15:0] CNT_TRIG;
    logic [7:0]  CNT_LOST;

    word_t fifo[$];
    vec_t  vecs[$];
    logic  stall = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;

    logic  m_pend;
    logic  m_inblk;
    int    m_idle;
    int    m_blk;
    int    m_trig;

    gtp_tx_sched dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .TRIG(TRIG),
        .TRIG_TS(TRIG_TS), .BLK_EMPTY(BLK_EMPTY), .BLK_DAT(BLK_DAT),
        .BLK_LAST(BLK_LAST), .BLK_RD(BLK_RD), .GTP_DATA(GTP_DATA),
        .GTP_K(GTP_K), .BUSY(BUSY), .CNT_BLK(CNT_BLK),
        .CNT_TRIG(CNT_TRIG), .CNT_LOST(CNT_LOST)
    );

    always #4 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        BLK_EMPTY = stall || (fifo.size() == 0);
        BLK_DAT   = (fifo.size() != 0) ? fifo[0].d : 16'h0;
        BLK_LAST  = (fifo.size() != 0) ? fifo[0].last : 1'b0;
    endtask

    task automatic push_blk(input logic [15:0] base, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.d    = base + 16'(i);
            w.last = (i == n - 1);
            fifo.push_back(w);
        end
    endtask

    task automatic load_seg(input int seg);
        case (seg)
            1, 3, 4: push_blk(16'h0001, 4);
            2: begin
                push_blk(16'h0A01, 3);
                push_blk(16'h0B01, 3);
            end
            5: begin
                push_blk(16'h00AA, 1);
                push_blk(16'h00BB, 1);
            end
            6: push_blk(16'h0011, 2);
            default: ;
        endcase
    endtask

    task automatic do_reset(input int seg);
        @(negedge CLK);
        RST_N  = 1'b0;
        ENABLE = 1'b0;
        TRIG   = 1'b0;
        stall  = 1'b0;
        fifo.delete();
        load_seg(seg);
        drive_fifo();
        #1;
        chk($sformatf("s%0d_rst_data", seg), 32'(GTP_DATA), 32'(COMMA));
        chk($sformatf("s%0d_rst_k", seg), 32'(GTP_K), 32'd1);
        chk($sformatf("s%0d_rst_busy", seg), 32'(BUSY), 32'd0);
        chk($sformatf("s%0d_rst_rd", seg), 32'(BLK_RD), 32'd0);
        chk($sformatf("s%0d_rst_cnts", seg),
            {8'(CNT_BLK), 8'(CNT_TRIG), CNT_LOST, 8'd0}, 32'd0);
        m_pend  = 1'b0;
        m_inblk = 1'b0;
        m_idle  = 0;
        m_blk   = 0;
        m_trig  = 0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic cyc(input logic en, input logic tr, input logic [15:0] ts,
                       input logic st, output logic rd);
        ENABLE  = en;
        TRIG    = tr;
        TRIG_TS = ts;
        stall   = st;
        drive_fifo();
        #1;
        rd = BLK_RD;
        chk("rd_when_empty", 32'(rd & BLK_EMPTY), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        if (rd && fifo.size() != 0) fifo.pop_front();
        TRIG  = 1'b0;
        stall = 1'b0;
        drive_fifo();
    endtask

    // Expected word for the coming edge, from the scheduling rules.
    task automatic model_step(input logic en, input logic tr, input logic empty,
                              input word_t head, output logic rd,
                              output logic [15:0] d, output logic k);
        logic was_idle;
        logic reload;
        was_idle = !m_inblk;
        reload   = 1'b0;
        rd = 1'b0;
        d  = COMMA;
        k  = 1'b1;
        if (m_pend) begin
            d = TRIG_K;
            m_trig++;
        end else if (m_inblk) begin
            if (empty) begin
                d = FILL_K;
            end else begin
                rd = 1'b1;
                d  = head.d;
                k  = 1'b0;
                if (head.last) begin
                    m_blk++;
                    m_inblk = 1'b0;
                    m_idle  = 0;
                end
            end
        end else if (en && !empty && m_idle >= MIN_GAP) begin
            rd = 1'b1;
            d  = head.d;
            k  = 1'b0;
            if (head.last) begin
                m_blk++;
                reload = 1'b1;
            end else begin
                m_inblk = 1'b1;
            end
        end
        if (was_idle) m_idle = reload ? 0 : ((m_idle < 1000) ? m_idle + 1 : m_idle);
        m_pend = tr;
    endtask

    task automatic v(input int seg, input logic en, input logic tr, input logic [15:0] ts,
                     input logic st, input logic [15:0] d, input logic k, input logic b);
        vec_t r;
        r = '{seg, en, tr, ts, st, d, k, b};
        vecs.push_back(r);
    endtask

    task automatic seg_end(input int seg);
        chk($sformatf("s%0d_cnt_blk", seg), 32'(CNT_BLK), 32'(EXP_BLK[seg]));
        chk($sformatf("s%0d_cnt_trig", seg), 32'(CNT_TRIG), 32'(EXP_TRIG[seg]));
        chk($sformatf("s%0d_cnt_lost", seg), 32'(CNT_LOST), 32'(EXP_LOST[seg]));
    endtask

    initial begin
        int          cur;
        logic        rd;
        logic        e_rd;
        logic [15:0] e_d;
        logic        e_k;
        logic        en;
        logic        tr;
        logic        st;
        word_t       head;

        for (int i = 0; i < 4; i++) v(0, 1, 0, 0, 0, COMMA, 1, 0);

        v(1, 1, 0, 0, 0, COMMA, 1, 0);
        v(1, 1, 0, 0, 0, COMMA, 1, 0);
        v(1, 1, 0, 0, 0, 16'h0001, 0, 1);
        v(1, 1, 0, 0, 0, 16'h0002, 0, 1);
        v(1, 1, 0, 0, 0, 16'h0003, 0, 1);
        v(1, 1, 0, 0, 0, 16'h0004, 0, 0);
        v(1, 1, 0, 0, 0, COMMA, 1, 0);
        v(1, 1, 0, 0, 0, COMMA, 1, 0);

        v(2, 1, 0, 0, 0, COMMA, 1, 0);
        v(2, 1, 0, 0, 0, COMMA, 1, 0);
        v(2, 1, 0, 0, 0, 16'h0A01, 0, 1);
        v(2, 1, 0, 0, 0, 16'h0A02, 0, 1);
        v(2, 1, 0, 0, 0, 16'h0A03, 0, 0);
        v(2, 1, 0, 0, 0, COMMA, 1, 0);
        v(2, 1, 0, 0, 0, COMMA, 1, 0);
        v(2, 1, 0, 0, 0, 16'h0B01, 0, 1);
        v(2, 1, 0, 0, 0, 16'h0B02, 0, 1);
        v(2, 1, 0, 0, 0, 16'h0B03, 0, 0);
        v(2, 1, 0, 0, 0, COMMA, 1, 0);

`ifndef TRIG_TIMESTAMP_EN
        v(3, 1, 0, 0, 0, COMMA, 1, 0);
        v(3, 1, 0, 0, 0, COMMA, 1, 0);
        v(3, 1, 1, 0, 0, 16'h0001, 0, 1);
        v(3, 1, 0, 0, 0, TRIG_K, 1, 1);
        v(3, 1, 0, 0, 0, 16'h0002, 0, 1);
        v(3, 1, 0, 0, 0, 16'h0003, 0, 1);
        v(3, 1, 0, 0, 0, 16'h0004, 0, 0);
        v(3, 1, 0, 0, 0, COMMA, 1, 0);
`endif

        v(4, 1, 0, 0, 0, COMMA, 1, 0);
        v(4, 1, 0, 0, 0, COMMA, 1, 0);
        v(4, 1, 0, 0, 0, 16'h0001, 0, 1);
        v(4, 1, 0, 0, 0, 16'h0002, 0, 1);
        v(4, 1, 0, 0, 1, FILL_K, 1, 1);
        v(4, 1, 0, 0, 1, FILL_K, 1, 1);
        v(4, 1, 0, 0, 1, FILL_K, 1, 1);
        v(4, 1, 0, 0, 0, 16'h0003, 0, 1);
        v(4, 1, 0, 0, 0, 16'h0004, 0, 0);
        v(4, 1, 0, 0, 0, COMMA, 1, 0);

`ifndef TRIG_TIMESTAMP_EN
        v(5, 1, 1, 0, 0, COMMA, 1, 0);
        v(5, 1, 0, 0, 0, TRIG_K, 1, 0);
        v(5, 1, 0, 0, 0, 16'h00AA, 0, 0);
        v(5, 1, 0, 0, 0, COMMA, 1, 0);
        v(5, 1, 0, 0, 0, COMMA, 1, 0);
        v(5, 1, 0, 0, 0, 16'h00BB, 0, 0);
        v(5, 1, 0, 0, 0, COMMA, 1, 0);

        v(6, 0, 1, 0, 0, COMMA, 1, 0);
        v(6, 0, 1, 0, 0, TRIG_K, 1, 0);
        v(6, 0, 0, 0, 0, TRIG_K, 1, 0);
        v(6, 0, 0, 0, 0, COMMA, 1, 0);
        v(6, 1, 0, 0, 0, 16'h0011, 0, 1);
        v(6, 0, 0, 0, 0, 16'h0012, 0, 0);
        v(6, 1, 0, 0, 0, COMMA, 1, 0);
`else
        v(7, 0, 1, 16'h1234, 0, COMMA, 1, 0);
        v(7, 0, 1, 16'h5678, 0, TRIG_K, 1, 0);
        v(7, 0, 1, 16'h9999, 0, 16'h1234, 0, 0);
        v(7, 0, 0, 16'h0000, 0, TRIG_K, 1, 0);
        v(7, 0, 0, 16'h0000, 0, 16'h5678, 0, 0);
        v(7, 0, 0, 16'h0000, 0, COMMA, 1, 0);
`endif

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].seg != cur) begin
                if (cur >= 0) seg_end(cur);
                cur = vecs[i].seg;
                do_reset(cur);
            end
            cyc(vecs[i].en, vecs[i].trig, vecs[i].ts, vecs[i].stall, rd);
            chk($sformatf("s%0d_v%0d_data", cur, i), 32'(GTP_DATA), 32'(vecs[i].exp_d));
            chk($sformatf("s%0d_v%0d_k", cur, i), 32'(GTP_K), 32'(vecs[i].exp_k));
            chk($sformatf("s%0d_v%0d_busy", cur, i), 32'(BUSY), 32'(vecs[i].exp_busy));
        end
        if (cur >= 0) seg_end(cur);

`ifndef TRIG_TIMESTAMP_EN
        do_reset(0);
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_reset(0);
            if (fifo.size() < 6 && $urandom_range(0, 3) == 0) begin
                push_blk(16'($urandom_range(0, 16'hFFFF)), int'($urandom_range(1, 5)));
            end
            en = ($urandom_range(0, 9) != 0);
            tr = ($urandom_range(0, 6) == 0);
            st = ($urandom_range(0, 5) == 0);
            head.d    = (fifo.size() != 0) ? fifo[0].d : 16'h0;
            head.last = (fifo.size() != 0) ? fifo[0].last : 1'b0;
            model_step(en, tr, st || (fifo.size() == 0), head, e_rd, e_d, e_k);
            cyc(en, tr, 16'h0, st, rd);
            chk($sformatf("rnd%0d_rd", c), 32'(rd), 32'(e_rd));
            chk($sformatf("rnd%0d_data", c), 32'(GTP_DATA), 32'(e_d));
            chk($sformatf("rnd%0d_k", c), 32'(GTP_K), 32'(e_k));
            chk($sformatf("rnd%0d_busy", c), 32'(BUSY), 32'(m_inblk));
        end
        chk("rnd_cnt_blk", 32'(CNT_BLK), 32'(16'(m_blk)));
        chk("rnd_cnt_trig", 32'(CNT_TRIG), 32'(16'(m_trig)));
        chk("rnd_cnt_lost", 32'(CNT_LOST), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
